// File: rtl/spi_pkg.sv
// Shared frame layout, register map and FSM encoding for the SPI initiator.
package spi_pkg;

  localparam int unsigned SPI_FRAME_W = 16;
  localparam int unsigned SPI_ADDR_W  = 7;
  localparam int unsigned SPI_DATA_W  = 8;
  localparam int unsigned RW_BIT      = 15;
  localparam int unsigned BIT_CNT_W   = 4;

  // Register map of the SPI target this controller talks to
  localparam logic [SPI_ADDR_W-1:0] ADDR_EN_OUT_7_0  = 7'h00;
  localparam logic [SPI_ADDR_W-1:0] ADDR_EN_OUT_15_8 = 7'h01;
  localparam logic [SPI_ADDR_W-1:0] ADDR_EN_PWM_7_0  = 7'h02;
  localparam logic [SPI_ADDR_W-1:0] ADDR_EN_PWM_15_8 = 7'h03;
  localparam logic [SPI_ADDR_W-1:0] ADDR_PWM_DUTY    = 7'h04;

  // Frame as it goes on the wire, MSB first
  typedef struct packed {
    logic                  rw;
    logic [SPI_ADDR_W-1:0] addr;
    logic [SPI_DATA_W-1:0] data;
  } spi_frame_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } spi_state_e;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: CLK_DIV-cycle half periods, starts low, with end-of-phase strobes.
module spi_sclk_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic sclk,
  output logic rise_c,
  output logic fall_c
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] half_cnt;
  logic             phase_end_c;

  // Strobes mark the last cycle of a phase; the level flips at the following edge
  assign phase_end_c = en && (half_cnt == DIV_W'(CLK_DIV - 1));
  assign rise_c      = phase_end_c && !sclk;
  assign fall_c      = phase_end_c && sclk;

  // Half-period counter and SCLK level; parked low while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_cnt <= '0;
      sclk     <= 1'b0;
    end else if (!en) begin
      half_cnt <= '0;
      sclk     <= 1'b0;
    end else if (phase_end_c) begin
      half_cnt <= '0;
      sclk     <= !sclk;
    end else begin
      half_cnt <= half_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 initiator sending one 16-bit {rw, addr, data} frame per request.
// Optional read-back of CIPO into rsp_rdata is enabled by defining SPI_CTRL_READ_EN.
module spi_controller
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2,
  parameter int unsigned IDLE_GAP = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [SPI_ADDR_W-1:0] req_addr,
  input  logic [SPI_DATA_W-1:0] req_wdata,
  output logic                  busy,
  output logic                  done,
  output logic [SPI_DATA_W-1:0] rsp_rdata,
  output logic                  SCLK,
  output logic                  nCS,
  output logic                  COPI,
  input  logic                  CIPO
);

  // Reject configurations the target synchroniser or framing cannot handle
  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("spi_controller: CLK_DIV must be >= 2");
  end
  if (CS_SETUP < 1 || CS_HOLD < 1 || IDLE_GAP < 1) begin : g_bad_timing
    $error("spi_controller: CS_SETUP, CS_HOLD and IDLE_GAP must be >= 1");
  end

  localparam int unsigned WAIT_MAX_SH = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int unsigned WAIT_MAX    = (WAIT_MAX_SH > IDLE_GAP) ? WAIT_MAX_SH : IDLE_GAP;
  localparam int unsigned WAIT_W      = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

  spi_state_e             state;
  logic [SPI_FRAME_W-1:0] shreg;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic                   last_bit;
  logic [WAIT_W-1:0]      wait_cnt;
  logic                   sclk_en_c;
  logic                   rise_c;
  logic                   fall_c;
  logic                   frame_end_c;
  spi_frame_t             frame_c;

  assign sclk_en_c   = (state == ST_SHIFT);
  assign frame_end_c = (state == ST_HOLD) && (wait_cnt == '0);
  assign frame_c     = '{rw: req_write, addr: req_addr, data: req_wdata};

  spi_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (sclk_en_c),
    .sclk  (SCLK),
    .rise_c(rise_c),
    .fall_c(fall_c)
  );

  // Frame sequencer: chip-select timing, bit shifting and handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      last_bit  <= 1'b0;
      wait_cnt  <= '0;
      nCS       <= 1'b1;
      COPI      <= 1'b0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            shreg     <= frame_c;
            COPI      <= frame_c.rw;
            nCS       <= 1'b0;
            busy      <= 1'b1;
            req_ready <= 1'b0;
            bit_cnt   <= '0;
            last_bit  <= 1'b0;
            wait_cnt  <= WAIT_W'(CS_SETUP - 1);
            state     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (wait_cnt == '0) state <= ST_SHIFT;
          else                wait_cnt <= wait_cnt - WAIT_W'(1);
        end
        ST_SHIFT: begin
          // Flag the 16th high phase so its falling edge ends the frame
          if (rise_c) last_bit <= (bit_cnt == BIT_CNT_W'(SPI_FRAME_W - 1));
          if (fall_c) begin
            if (last_bit) begin
              wait_cnt <= WAIT_W'(CS_HOLD - 1);
              state    <= ST_HOLD;
            end else begin
              shreg   <= {shreg[SPI_FRAME_W-2:0], 1'b0};
              COPI    <= shreg[SPI_FRAME_W-2];
              bit_cnt <= bit_cnt + BIT_CNT_W'(1);
            end
          end
        end
        ST_HOLD: begin
          if (frame_end_c) begin
            nCS      <= 1'b1;
            COPI     <= 1'b0;
            done     <= 1'b1;
            wait_cnt <= WAIT_W'(IDLE_GAP - 1);
            state    <= ST_GAP;
          end else begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end
        end
        ST_GAP: begin
          if (wait_cnt == '0) begin
            busy      <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SPI_CTRL_READ_EN
  logic                  is_read;
  logic [SPI_DATA_W-1:0] rx_sh;

  // Read-back: sample CIPO at the end of the high phase of the data bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_read   <= 1'b0;
      rx_sh     <= '0;
      rsp_rdata <= '0;
    end else begin
      if (state == ST_IDLE && req_valid) is_read <= !req_write;
      if (sclk_en_c && fall_c && bit_cnt[BIT_CNT_W-1])
        rx_sh <= {rx_sh[SPI_DATA_W-2:0], CIPO};
      if (frame_end_c && is_read) rsp_rdata <= rx_sh;
    end
  end
`else
  logic unused_cipo;
  assign unused_cipo = CIPO;

  // Read-back disabled: response data stays zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rsp_rdata <= '0;
    else        rsp_rdata <= '0;
  end
`endif

endmodule

// File: tb/tb_spi_controller.sv
// Self-checking bench for spi_controller: cycle-accurate waveform model derived
// from frame timing arithmetic, a bus-side target that decodes frames and drives CIPO,
// and directed plus randomized requests.
`timescale 1ns/1ps
module tb_spi_controller;

  localparam int unsigned D    = 4;
  localparam int unsigned S    = 2;
  localparam int unsigned H    = 2;
  localparam int unsigned G    = 2;
  localparam int unsigned N    = 16 * 2 * D;
  localparam int unsigned LOW  = S + N + H;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_write = 1'b0;
  logic [6:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       busy;
  logic       done;
  logic [7:0] rsp_rdata;
  logic       SCLK;
  logic       nCS;
  logic       COPI;
  logic       CIPO = 1'b0;

  spi_controller #(
    .CLK_DIV (D),
    .CS_SETUP(S),
    .CS_HOLD (H),
    .IDLE_GAP(G)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .busy     (busy),
    .done     (done),
    .rsp_rdata(rsp_rdata),
    .SCLK     (SCLK),
    .nCS      (nCS),
    .COPI     (COPI),
    .CIPO     (CIPO)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          cyc = 0;
  int          m_acc = 0;
  int          m_acc_cnt = 0;
  bit          m_has = 1'b0;
  logic [15:0] m_frame = '0;
  logic [7:0]  m_tgt = '0;
  logic [7:0]  m_rsp = '0;
  logic [7:0]  tb_tgt = '0;

  function automatic bit model_busy(input int c);
    return m_has && (c - m_acc) >= 1 && (c - m_acc) <= int'(LOW + G);
  endfunction

  // Accept when the model says the controller is free; track response register
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_has = 1'b0;
      m_rsp = '0;
    end else begin
      if (req_valid && !model_busy(cyc)) begin
        m_acc   = cyc;
        m_has   = 1'b1;
        m_frame = {req_write, req_addr, req_wdata};
        m_tgt   = tb_tgt;
        m_acc_cnt++;
      end
      cyc++;
`ifdef SPI_CTRL_READ_EN
      if (m_has && (cyc - m_acc) == int'(LOW + 1) && !m_frame[15]) m_rsp = m_tgt;
`endif
    end
  end

  // ---------------- bus target / monitor + per-cycle compare ----------------
  logic [15:0] rx_frame = '0;
  int          rx_bits = 0;
  int          fall_cnt = 0;
  int          low_cnt = 0;
  int          high_cnt = 0;
  int          last_low = 0;
  int          last_high = 0;
  logic [15:0] last_frame = '0;
  int          n_abort = 0;
  int          n_done = 0;
  logic        sclk_prev = 1'b0;
  logic        ncs_prev = 1'b1;
  logic [7:0]  tgt_regs [5];

  initial for (int i = 0; i < 5; i++) tgt_regs[i] = '0;

  always @(negedge clk) begin
    int          k;
    int          j;
    int          b;
    logic        e_ncs, e_sclk, e_copi, e_done, e_busy;
    logic [15:0] fr;

    // target side: capture COPI on rising SCLK, count falls for CIPO bit position
    if (!nCS) begin
      low_cnt++;
      if (SCLK && !sclk_prev) begin
        rx_frame = {rx_frame[14:0], COPI};
        rx_bits++;
      end
      if (!SCLK && sclk_prev) fall_cnt++;
    end
    if (nCS && !ncs_prev) begin
      if (rx_bits == 16) begin
        chk("bus_frame", 32'(rx_frame), 32'(m_frame));
        chk("ncs_low_len", 32'(low_cnt), 32'(LOW));
        last_frame = rx_frame;
        last_low   = low_cnt;
        if (rx_frame[15] && rx_frame[14:8] < 7'd5) tgt_regs[rx_frame[10:8]] = rx_frame[7:0];
      end else begin
        n_abort++;
      end
      high_cnt = 0;
    end
    if (!nCS && ncs_prev) last_high = high_cnt;
    if (nCS) begin
      high_cnt++;
      low_cnt  = 0;
      rx_bits  = 0;
      fall_cnt = 0;
    end
    if (!nCS && fall_cnt >= 8 && fall_cnt <= 15) CIPO = m_tgt[15 - fall_cnt];
    else                                          CIPO = 1'b0;
    sclk_prev = SCLK;
    ncs_prev  = nCS;
    if (done === 1'b1) n_done++;

    // expected waveform from the frame timeline
    k      = m_has ? (cyc - m_acc) : -1000000;
    fr     = m_frame;
    e_ncs  = !(k >= 1 && k <= int'(LOW));
    e_sclk = 1'b0;
    e_copi = 1'b0;
    if (k > int'(S) && k <= int'(S + N)) begin
      j      = k - int'(S) - 1;
      e_sclk = (j % int'(2 * D)) >= int'(D);
    end
    if (k >= 1 && k <= int'(LOW)) begin
      if (k <= int'(S))          b = 15;
      else if (k <= int'(S + N)) b = 15 - (k - int'(S) - 1) / int'(2 * D);
      else                       b = 0;
      e_copi = fr[b];
    end
    e_done = (k == int'(LOW + 1));
    e_busy = model_busy(cyc);
    chk("ncs", 32'(nCS), 32'(e_ncs));
    chk("sclk", 32'(SCLK), 32'(e_sclk));
    chk("copi", 32'(COPI), 32'(e_copi));
    chk("done", 32'(done), 32'(e_done));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("req_ready", 32'(req_ready), 32'(!e_busy));
    chk("rsp_rdata", 32'(rsp_rdata), 32'(m_rsp));
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic w, input logic [6:0] a, input logic [7:0] d, input logic [7:0] t);
    int n0;
    n0        = m_acc_cnt;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    tb_tgt    = t;
    for (int i = 0; i < 2000 && m_acc_cnt == n0; i++) @(negedge clk);
    if (m_acc_cnt == n0) chk("accept_timeout", 32'(m_acc_cnt), 32'(n0 + 1));
    req_valid = 1'b0;
    // scramble fields after accept: the controller must ignore them
    req_write = 1'($urandom);
    req_addr  = 7'($urandom);
    req_wdata = 8'($urandom);
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!model_busy(cyc)) break;
    end
    if (i == 2000) chk("idle_timeout", 32'(i), 32'(0));
    @(negedge clk);
    #1;
  endtask

  logic [7:0] exp_rd;
  logic [7:0] snap [5];
  int         acc1;
  int         done0;
  int         abort0;
  int         fi;

  initial begin
    // reset values
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ncs", 32'(nCS), 32'd1);
    chk("rst_sclk", 32'(SCLK), 32'd0);
    chk("rst_copi", 32'(COPI), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rsp", 32'(rsp_rdata), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // write 0x00 <- 0xA5
    done0 = n_done;
    send(1'b1, 7'h00, 8'hA5, 8'h00);
    wait_idle();
    chk("t1_frame", 32'(last_frame), 32'h80A5);
    chk("t1_low", 32'(last_low), 32'd132);
    chk("t1_done_cnt", 32'(n_done - done0), 32'd1);
    chk("t1_reg0", 32'(tgt_regs[0]), 32'hA5);

    // back-to-back with valid held: 0x04 <- 0x80 then 0x01 <- 0x3C
    send(1'b1, 7'h04, 8'h80, 8'h00);
    acc1 = m_acc;
    send(1'b1, 7'h01, 8'h3C, 8'h00);
    chk("t2_acc_to_acc", 32'(m_acc - acc1), 32'd135);
    wait_idle();
    chk("t2_gap_high", 32'(last_high), 32'd3);
    chk("t2_reg4", 32'(tgt_regs[4]), 32'h80);
    chk("t2_reg1", 32'(tgt_regs[1]), 32'h3C);

    // read 0x02, target returns 0x3C
`ifdef SPI_CTRL_READ_EN
    exp_rd = 8'h3C;
`else
    exp_rd = 8'h00;
`endif
    send(1'b0, 7'h02, 8'h11, 8'h3C);
    wait_idle();
    chk("t3_frame", 32'(last_frame), 32'h0211);
    chk("t3_rsp", 32'(rsp_rdata), 32'(exp_rd));

    // out-of-map address: frame goes out, no register changes, rsp held
    for (int i = 0; i < 5; i++) snap[i] = tgt_regs[i];
    send(1'b1, 7'h7F, 8'h11, 8'h00);
    wait_idle();
    chk("t4_frame", 32'(last_frame), 32'hFF11);
    for (int i = 0; i < 5; i++) chk("t4_regs", 32'(tgt_regs[i]), 32'(snap[i]));
    chk("t4_rsp_held", 32'(rsp_rdata), 32'(exp_rd));

    // reset during bit 7 of a write to 0x02
    done0  = n_done;
    abort0 = n_abort;
    send(1'b1, 7'h02, 8'h5A, 8'h00);
    for (fi = 0; fi < 500; fi++) begin
      @(negedge clk);
      #1;
      if (fall_cnt == 7) break;
    end
    if (fi == 500) chk("t5_bit7_timeout", 32'(fi), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_ncs_async", 32'(nCS), 32'd1);
    chk("t5_sclk_async", 32'(SCLK), 32'd0);
    chk("t5_busy_async", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("t5_ready", 32'(req_ready), 32'd1);
    chk("t5_abort", 32'(n_abort - abort0), 32'd1);
    chk("t5_no_done", 32'(n_done - done0), 32'd0);
    chk("t5_reg2", 32'(tgt_regs[2]), 32'h00);

    // randomized requests, some back-to-back
    for (int it = 0; it < 24; it++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      if (gap > 0) repeat (gap) @(negedge clk);
      send(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom));
    end
    wait_idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
